// File: rtl/audio_speed_pkg.sv
// Shared divider constants and the resolved per-cycle speed command for the audio speed control.
// Also used by the sample fetch logic.
package audio_speed_pkg;

  localparam int unsigned AUDIO_DIV_WIDTH   = 32;
  localparam int unsigned AUDIO_DIV_DEFAULT = 1136;
  localparam int unsigned AUDIO_DIV_MIN     = 568;
  localparam int unsigned AUDIO_DIV_MAX     = 2272;
  localparam int unsigned AUDIO_DIV_STEP    = 64;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_UP,
    CMD_DOWN,
    CMD_RESET
  } speed_cmd_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for one synchronised button level.
// With AUTO_REPEAT_EN defined it also re-fires every REPEAT_CYCLES while rpt_en_i stays high.
module edge_detect #(
  parameter int unsigned REPEAT_CYCLES = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  input  logic rpt_en_i,
  output logic event_o
);

  logic prev_q, prev_d;
  logic rise;

  assign prev_d = level_i;
  assign rise   = level_i & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HoldW = $clog2(REPEAT_CYCLES + 2);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(REPEAT_CYCLES);

  logic [HoldW-1:0] hold_q, hold_d;
  logic             repeat_hit;

  assign repeat_hit = rpt_en_i & (hold_q == HoldMax);

  // hold_q counts cycles since the last event; any loss of rpt_en_i clears it.
  always_comb begin
    hold_d = '0;
    if (rpt_en_i) begin
      hold_d = (rise | repeat_hit) ? HoldW'(1) : hold_q + HoldW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  assign event_o = rise | repeat_hit;
`else
  logic unused_rpt;
  assign unused_rpt = rpt_en_i ^ (REPEAT_CYCLES == 32'd0);
  assign event_o    = rise;
`endif

endmodule

// File: rtl/audio_speed_ctrl.sv
// Button-driven saturating audio clock divider plus the sample-rate strobe derived from it.
// Optional hold-to-repeat on up/down buttons is enabled by defining AUTO_REPEAT_EN.
module audio_speed_ctrl
  import audio_speed_pkg::*;
#(
  parameter int unsigned WIDTH         = AUDIO_DIV_WIDTH,
  parameter int unsigned DIV_DEFAULT   = AUDIO_DIV_DEFAULT,
  parameter int unsigned DIV_MIN       = AUDIO_DIV_MIN,
  parameter int unsigned DIV_MAX       = AUDIO_DIV_MAX,
  parameter int unsigned STEP          = AUDIO_DIV_STEP,
  parameter int unsigned REPEAT_CYCLES = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             speedUp,
  input  logic             speedDown,
  input  logic             speedReset,
  output logic [WIDTH-1:0] outputClkDiv,
  output logic             sampleTick,
  output logic             atMin,
  output logic             atMax
);

  localparam logic [WIDTH-1:0] DivDefault = WIDTH'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] DivMin     = WIDTH'(DIV_MIN);
  localparam logic [WIDTH-1:0] DivMax     = WIDTH'(DIV_MAX);
  localparam logic [WIDTH:0]   StepExt    = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   DivMinExt  = (WIDTH + 1)'(DIV_MIN);
  localparam logic [WIDTH:0]   DivMaxExt  = (WIDTH + 1)'(DIV_MAX);

  logic up_evt, down_evt, rst_evt;
  logic up_rpt_en, down_rpt_en;

  // Repeat only while exactly one direction is held and no speed reset is firing.
  assign up_rpt_en   = speedUp & ~speedDown & ~rst_evt;
  assign down_rpt_en = speedDown & ~speedUp & ~rst_evt;

  edge_detect #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_up (
    .clk      (clk),
    .reset    (reset),
    .level_i  (speedUp),
    .rpt_en_i (up_rpt_en),
    .event_o  (up_evt)
  );

  edge_detect #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_down (
    .clk      (clk),
    .reset    (reset),
    .level_i  (speedDown),
    .rpt_en_i (down_rpt_en),
    .event_o  (down_evt)
  );

  edge_detect #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_rst (
    .clk      (clk),
    .reset    (reset),
    .level_i  (speedReset),
    .rpt_en_i (1'b0),
    .event_o  (rst_evt)
  );

  speed_cmd_t       cmd;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   div_up, div_dn;
  logic             at_min_q, at_min_d, at_max_q, at_max_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, active_q, active_d;
  logic             wrap;

  always_comb begin
    cmd = CMD_NONE;
    if (rst_evt) begin
      cmd = CMD_RESET;
    end else if (up_evt && !down_evt) begin
      cmd = CMD_UP;
    end else if (down_evt && !up_evt) begin
      cmd = CMD_DOWN;
    end
  end

  // One extra bit makes underflow visible in the MSB and keeps overflow from wrapping.
  always_comb begin
    div_up = {1'b0, div_q} - StepExt;
    div_dn = {1'b0, div_q} + StepExt;
    div_d  = div_q;
    unique case (cmd)
      CMD_RESET: div_d = DivDefault;
      CMD_UP:    div_d = (div_up[WIDTH] || (div_up < DivMinExt)) ? DivMin : div_up[WIDTH-1:0];
      CMD_DOWN:  div_d = (div_dn > DivMaxExt) ? DivMax : div_dn[WIDTH-1:0];
      default:   div_d = div_q;
    endcase
    at_min_d = (div_d == DivMin);
    at_max_d = (div_d == DivMax);
  end

  // The active period is latched only at wrap, so mid-period changes apply next period.
  always_comb begin
    wrap     = (cnt_q == active_q - WIDTH'(1));
    cnt_d    = wrap ? '0 : cnt_q + WIDTH'(1);
    active_d = wrap ? div_q : active_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DivDefault;
      at_min_q <= (DIV_DEFAULT == DIV_MIN);
      at_max_q <= (DIV_DEFAULT == DIV_MAX);
      cnt_q    <= '0;
      active_q <= DivDefault;
    end else begin
      div_q    <= div_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign outputClkDiv = div_q;
  assign atMin        = at_min_q;
  assign atMax        = at_max_q;
  assign sampleTick   = wrap & ~reset;

endmodule

// File: doc/audio_speed_ctrl.md
# audio_speed_ctrl

- Parametrised successor to the audio playback-speed block.
- Turns speed-up, speed-down and speed-reset button levels into a saturating clock-divider value.
- Also generates the sample-rate strobe from that value.
- Sits between the debounced button inputs and the audio sample fetch logic; `sampleTick` replaces the external divider.

## Interface
Parameters:
- `WIDTH`, 32: divider width in bits.
- `DIV_DEFAULT`, 1136: divider after reset or `speedReset`, in clk cycles per sample.
- `DIV_MIN`, 568: fastest allowed divider.
- `DIV_MAX`, 2272: slowest allowed divider.
- `STEP`, 64: divider change per accepted button event.
- `REPEAT_CYCLES`, 12500000: hold time before auto-repeat. Used only with `AUTO_REPEAT_EN`.
- Legal range: 2 ≤ `DIV_MIN` ≤ `DIV_DEFAULT` ≤ `DIV_MAX` < 2^`WIDTH`, and `STEP` ≥ 1.

Ports:
- `clk`  in  1  single clock. All logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `speedUp`  in  1  level, already synchronised. Rising edge decreases the divider.
- `speedDown`  in  1  level, already synchronised. Rising edge increases the divider.
- `speedReset`  in  1  level, already synchronised. Rising edge restores `DIV_DEFAULT`.
- `outputClkDiv`  out  `WIDTH`  current requested divider, registered.
- `sampleTick`  out  1  one-cycle strobe, once per active divider period.
- `atMin`  out  1  `outputClkDiv == DIV_MIN`.
- `atMax`  out  1  `outputClkDiv == DIV_MAX`.

## Operation
Edge detection:
- Each button input is registered once into a "previous" flop.
- event = in & ~prev.
- Levels held high produce one event only, unless auto-repeat is enabled.

Divider update, applied on the edge where the event is true, in priority order:
1. reset: `outputClkDiv` = `DIV_DEFAULT`.
2. speedReset event: `outputClkDiv` = `DIV_DEFAULT`.
3. Up and down events on the same cycle: no change.
4. Up event: `outputClkDiv` = max(`outputClkDiv` − `STEP`, `DIV_MIN`).
5. Down event: `outputClkDiv` = min(`outputClkDiv` + `STEP`, `DIV_MAX`).

Arithmetic:
- Computed in `WIDTH`+1 bits, so subtraction underflow and addition overflow saturate correctly.
- No wrap-around is ever possible.

Sample counter:
- `cnt` counts 0 … `activeDiv`−1.
- At `cnt == activeDiv−1`: `sampleTick` = 1 for that cycle, `cnt` → 0, and `activeDiv` ← `outputClkDiv`.
- A divider change mid-period therefore never shortens or stretches the current period. It takes effect from the next period.
- `activeDiv` is internal.

Flags:
- `atMin` and `atMax` are registered together with `outputClkDiv`, so they are always consistent with it.

Reset values:
- `outputClkDiv` = `DIV_DEFAULT`, `activeDiv` = `DIV_DEFAULT`, `cnt` = 0.
- `sampleTick` = 0, `atMin` = (`DIV_DEFAULT == DIV_MIN`), `atMax` = (`DIV_DEFAULT == DIV_MAX`).
- All prev flops = 0. A button already high when reset is released therefore yields one event on the first cycle out of reset.

## Timing
- Latency: an input first sampled high at edge k updates `outputClkDiv` at edge k. The new value is visible in cycle k+1.
- The first `sampleTick` after reset is asserted in cycle `DIV_DEFAULT` (cnt = `DIV_DEFAULT`−1). Subsequent ticks are exactly `activeDiv` cycles apart.
- Reset asserted mid-period: takes effect at the next edge and aborts the period. No tick is produced in the reset cycle.
- With `outputClkDiv` already saturated, further events in the same direction leave it and the flags unchanged.

## Configuration
`AUTO_REPEAT_EN`:
- Defined: while exactly one of `speedUp`/`speedDown` stays high, a per-button hold counter generates an additional event every `REPEAT_CYCLES` cycles after the initial edge.
- The hold counter clears when the button is released, when both buttons are high, on a `speedReset` event, and on reset.
- Not defined: edge-only behaviour, no hold counters are synthesised, and `REPEAT_CYCLES` is ignored.

## Structure
Package `audio_speed_pkg`:
- `AUDIO_DIV_WIDTH` and the default `DIV_DEFAULT`/`DIV_MIN`/`DIV_MAX`/`STEP` constants, shared with the sample fetch logic.
- A `speed_cmd_t` enum {`CMD_NONE`, `CMD_UP`, `CMD_DOWN`, `CMD_RESET`} for the resolved per-cycle command.

Sub-module:
- `edge_detect`: one flop plus rising-edge output, with the same `clk`/`reset`.
- Instantiated three times.
- Also holds the auto-repeat counter under `AUTO_REPEAT_EN`.

## Test plan
Bench parameters: `DIV_DEFAULT`=8, `DIV_MIN`=4, `DIV_MAX`=12, `STEP`=3, `WIDTH`=8, `REPEAT_CYCLES`=5.
1. Release reset with no buttons → `outputClkDiv`=8, `atMin`=`atMax`=0, `sampleTick` in cycles 8, 16, 24.
2. `speedUp` pulse, then a second pulse → 5, then 4 (saturated), `atMin`=1. A third pulse leaves 4.
3. Hold `speedDown` 20 cycles, without the macro → single step 8→11. Then a further pulse → 12 (saturated), `atMax`=1.
4. `speedUp`+`speedDown` rising on the same cycle → unchanged at 8. Then `speedReset`+`speedUp` together → 8.
5. Change 8→5 with `cnt`=3 → the current period still ends 8 cycles after the previous tick; the next tick comes 5 cycles later.
6. With `AUTO_REPEAT_EN`, hold `speedDown` from 4 → 7 at the edge, then 10 after 5 cycles, then 12. Assert reset mid-hold → 8, `cnt`=0.
